canonical_row_feeder: RTL and testbench
=======================================

Name: canonical_row_feeder

Overview:
- Transmit side of the canonical-form row interface: captures a stabilizer tableau (X-block, Z-block, literal block) and streams it row by row into the canonical reduction unit's valid_in/row input.
- Holds off further traffic while the reduction unit runs its second-stage pass, then signals completion.
- Sits between the tableau storage/update logic and the canonical reduction unit.

Parameters:
- num_qubit, 4, tableau dimension N; each block is N rows of N bits.
- WAIT_CYCLES, 4*num_qubit+2, cycles held busy after the last row is sent; covers the second-stage pass plus drain.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_new  input  1  asynchronous, active-high reset
- start  input  1  request to send one tableau; sampled only in IDLE
- x_block  input  [0:num_qubit*num_qubit-1]  X-block; row r = bits [r*N .. r*N+N-1]
- z_block  input  [0:num_qubit*num_qubit-1]  Z-block, same packing
- lit_block  input  [0:num_qubit*num_qubit-1]  literal block, same packing
- valid_out  output  1  row valid; drives the canonical unit's valid_in
- row_out  output  [0:num_qubit-1]  current row data
- row_blk  output  2  block of current row: 0=X, 1=Z, 2=literal
- row_idx  output  32  row index within the block, 0..N-1
- busy  output  1  high from start acceptance until the done pulse inclusive
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset, asynchronous, any state: state=IDLE, shadow registers=0, counters=0. valid_out, row_out, row_blk, row_idx, busy and done all read 0.
- All outputs are registered; none depend combinationally on inputs.
- State IDLE:
  - busy=0.
  - start=1 copies x_block, z_block and lit_block into shadow registers, zeroes the row counter, sets busy=1 and moves to SEND.
  - Inputs may change freely after the capture edge.
- State SEND: exactly 3N consecutive cycles with valid_out=1, no gaps, no backpressure.
  - Send counter k runs 0..3N-1.
  - k<N: row_blk=0, row_idx=k, row_out=x_shadow row k.
  - N<=k<2N: row_blk=1, row_idx=k-N, row_out=z_shadow row k-N.
  - 2N<=k<3N: row_blk=2, row_idx=k-2N, row_out=lit_shadow row k-2N.
  - After k=3N-1: valid_out=0, row_out/row_blk/row_idx cleared to 0, move to WAIT with the wait counter at 0.
- State WAIT:
  - valid_out=0, busy=1.
  - Runs exactly WAIT_CYCLES cycles, then moves to DONE.
  - WAIT_CYCLES=0 goes straight to DONE.
- State DONE: one cycle with done=1 and busy=1, then IDLE.
- Latency with start high at edge t:
  - First valid row at cycle t+1; last row at t+3N.
  - done at t+3N+WAIT_CYCLES+1; busy=0 again at t+3N+WAIT_CYCLES+2.
- start=1 in SEND, WAIT or DONE is ignored and not queued; shadow data are not disturbed.
- Back-to-back: start held high continuously restarts at the first IDLE cycle after done, so valid_out bursts are separated by WAIT_CYCLES+2 idle-valid cycles.
- Counter widths: 32-bit; comparisons against 3N-1 and WAIT_CYCLES-1 use the full width.
- Reset asserted mid-SEND or mid-WAIT aborts immediately. After release the block sits in IDLE with outputs at their reset values and needs a new start.
- Unused/illegal state encodings return to IDLE on the next edge with outputs cleared.

Test Plan:
- Reset check: assert rst_new mid-cycle, no clock -> all outputs 0 immediately; after release valid_out stays 0 with start=0 for 20 cycles.
- Basic stream, N=2, x=4'b1001, z=4'b0110, lit=4'b1100, start pulse at cycle 0:
  - cycles 1..6 valid_out=1; row_out = 10, 01, 01, 10, 11, 00.
  - row_blk = 0,0,1,1,2,2; row_idx = 0,1,0,1,0,1.
  - done at cycle 6+WAIT_CYCLES+1=17 with default WAIT_CYCLES=10.
- Capture isolation: change x_block to all 1s at cycle 1 -> streamed X rows still 10, 01.
- Ignored start: pulse start at cycle 3 and again in WAIT -> exactly one burst of 6 valid rows and one done pulse.
- Back-to-back: hold start high -> second burst begins the cycle after busy falls, i.e. cycle 19, with identical row sequence.
- Abort: assert rst_new at cycle 4 -> valid_out drops asynchronously; after release no done pulse appears; a new start produces a full 6-row burst.

Source files
------------

// File: rtl/canonical_row_feeder.sv
// Streams a captured stabilizer tableau (X, Z, literal blocks) row by row into the canonical
// reduction unit, then holds busy through its second-stage pass and pulses done.
module canonical_row_feeder #(
   parameter int num_qubit   = 4,
   parameter int WAIT_CYCLES = 4*num_qubit+2
) (
   input  logic                           clk,
   input  logic                           rst_new,
   input  logic                           start,
   input  logic [0:num_qubit*num_qubit-1] x_block,
   input  logic [0:num_qubit*num_qubit-1] z_block,
   input  logic [0:num_qubit*num_qubit-1] lit_block,
   output logic                           valid_out,
   output logic [0:num_qubit-1]           row_out,
   output logic [1:0]                     row_blk,
   output logic [31:0]                    row_idx,
   output logic                           busy,
   output logic                           done
);
   localparam int          NN        = num_qubit*num_qubit;
   localparam logic [31:0] N1        = 32'(num_qubit);
   localparam logic [31:0] N2        = 32'(2*num_qubit);
   localparam logic [31:0] LAST_ROW  = 32'(3*num_qubit-1);
   localparam logic [31:0] WAIT_LEN  = 32'(WAIT_CYCLES);
   localparam logic [31:0] LAST_WAIT = 32'(WAIT_CYCLES-1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [0:NN-1]     r_x, r_z, r_lit, w_x_nxt, w_z_nxt, w_lit_nxt, w_src;
   logic [31:0]       r_k, w_k_nxt, r_wcnt, w_wcnt_nxt;
   logic              r_valid, w_valid_nxt, r_busy, w_busy_nxt, r_done, w_done_nxt;
   logic [0:num_qubit-1] r_row, w_row_nxt;
   logic [1:0]        r_blk, w_blk_nxt;
   logic [31:0]       r_idx, w_idx_nxt;
   logic              w_load;

   always_ff @(posedge clk or posedge rst_new) begin
      if (rst_new) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_z_nxt     = r_z;
      w_lit_nxt   = r_lit;
      w_k_nxt     = r_k;
      w_wcnt_nxt  = r_wcnt;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            if (start) begin
               w_x_nxt     = x_block;
               w_z_nxt     = z_block;
               w_lit_nxt   = lit_block;
               w_k_nxt     = '0;
               w_busy_nxt  = 1'b1;
               w_load      = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            w_busy_nxt = 1'b1;
            if (r_k == LAST_ROW) begin
               w_wcnt_nxt = '0;
               if (WAIT_LEN == 32'd0) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else begin
               w_k_nxt = r_k + 32'd1;
               w_load  = 1'b1;
            end
         end
         S_WAIT: begin
            w_busy_nxt = 1'b1;
            if (r_wcnt == LAST_WAIT) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_wcnt_nxt = r_wcnt + 32'd1;
            end
         end
         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_busy_nxt  = 1'b0;
            w_k_nxt     = '0;
            w_wcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Row fields come from the next shadow values so the capture edge already presents row 0.
   always_comb begin
      w_valid_nxt = w_load;
      w_blk_nxt   = 2'd0;
      w_idx_nxt   = '0;
      w_row_nxt   = '0;
      w_src       = '0;
      if (w_load) begin
         if (w_k_nxt < N1) begin
            w_idx_nxt = w_k_nxt;
            w_src     = w_x_nxt;
         end else if (w_k_nxt < N2) begin
            w_blk_nxt = 2'd1;
            w_idx_nxt = w_k_nxt - N1;
            w_src     = w_z_nxt;
         end else begin
            w_blk_nxt = 2'd2;
            w_idx_nxt = w_k_nxt - N2;
            w_src     = w_lit_nxt;
         end
         for (int i = 0; i < num_qubit; i++) begin
            if (w_idx_nxt == 32'(i)) w_row_nxt = w_src[i*num_qubit +: num_qubit];
         end
      end
   end

   always_ff @(posedge clk or posedge rst_new) begin
      if (rst_new) begin
         r_x     <= '0;
         r_z     <= '0;
         r_lit   <= '0;
         r_k     <= '0;
         r_wcnt  <= '0;
         r_valid <= 1'b0;
         r_row   <= '0;
         r_blk   <= 2'd0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_x     <= w_x_nxt;
         r_z     <= w_z_nxt;
         r_lit   <= w_lit_nxt;
         r_k     <= w_k_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_valid <= w_valid_nxt;
         r_row   <= w_row_nxt;
         r_blk   <= w_blk_nxt;
         r_idx   <= w_idx_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign valid_out = r_valid;
   assign row_out   = r_row;
   assign row_blk   = r_blk;
   assign row_idx   = r_idx;
   assign busy      = r_busy;
   assign done      = r_done;
endmodule

// File: tb/tb_canonical_row_feeder.sv
// Bench for canonical_row_feeder: table-driven bursts, hand-written corner sequences and a random
// phase, all checked against a cycle-offset reference model of the transfer timeline.
module tb_canonical_row_feeder;
   localparam int N    = 2;
   localparam int NN   = N*N;
   localparam int W    = 4*N+2;
   localparam int ROWS = 3*N;

   logic          clk = 1'b0;
   logic          rst_new, start;
   logic [0:NN-1] x_block, z_block, lit_block;
   logic          valid_out, busy, done;
   logic [0:N-1]  row_out;
   logic [1:0]    row_blk;
   logic [31:0]   row_idx;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   canonical_row_feeder #(.num_qubit(N)) dut (
      .clk(clk), .rst_new(rst_new), .start(start),
      .x_block(x_block), .z_block(z_block), .lit_block(lit_block),
      .valid_out(valid_out), .row_out(row_out), .row_blk(row_blk), .row_idx(row_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remembers the edge a transfer was accepted on and the blocks seen then;
   // every output is a function of the number of edges since acceptance.
   int            ecnt = 0;
   int            acc  = 0;
   bit            acc_vld = 0;
   logic [0:NN-1] m_blk [3];

   always @(posedge clk or posedge rst_new) begin
      if (rst_new) acc_vld = 0;
      else begin
         ecnt++;
         if (start === 1'b1 && (!acc_vld || ecnt - acc >= ROWS + W + 2)) begin
            acc      = ecnt;
            acc_vld  = 1;
            m_blk[0] = x_block;
            m_blk[1] = z_block;
            m_blk[2] = lit_block;
         end
      end
   end

   always @(negedge clk) begin
      int            d;
      logic          e_v, e_b, e_d;
      logic [0:N-1]  e_row;
      logic [1:0]    e_blk;
      logic [31:0]   e_idx;
      logic [0:NN-1] src;
      if (chk_en) begin
         d     = acc_vld ? ecnt - acc : 1 << 20;
         e_v   = (d < ROWS);
         e_b   = (d <= ROWS + W);
         e_d   = (d == ROWS + W);
         e_row = '0;
         e_blk = 2'd0;
         e_idx = '0;
         if (e_v) begin
            e_blk = 2'(d / N);
            e_idx = 32'(d % N);
            src   = m_blk[d / N];
            e_row = src[(d % N)*N +: N];
         end
         chk("sb_valid", 32'(valid_out), 32'(e_v));
         chk("sb_row",   32'(row_out),   32'(e_row));
         chk("sb_blk",   32'(row_blk),   32'(e_blk));
         chk("sb_idx",   row_idx,        e_idx);
         chk("sb_busy",  32'(busy),      32'(e_b));
         chk("sb_done",  32'(done),      32'(e_d));
      end
   end

   typedef struct {
      logic [0:NN-1]     x;
      logic [0:NN-1]     z;
      logic [0:NN-1]     l;
      logic [0:ROWS*N-1] rows;
      bit                mod_x;
   } vec_t;

   vec_t vecs [4];

   // Entered and left #1 after a rising edge; start is raised in "cycle 0".
   task automatic run_burst(input vec_t v, input string tag);
      logic [0:N-1] er;
      int           dc;
      x_block = v.x; z_block = v.z; lit_block = v.l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (v.mod_x) x_block = ~v.x;
      for (int k = 0; k < ROWS; k++) begin
         @(negedge clk);
         er = v.rows[k*N +: N];
         chk({tag, "_valid"}, 32'(valid_out), 32'd1);
         chk({tag, "_row"},   32'(row_out),   32'(er));
         chk({tag, "_blk"},   32'(row_blk),   32'(k / N));
         chk({tag, "_idx"},   row_idx,        32'(k % N));
         @(posedge clk); #1;
      end
      dc = 0;
      for (int c = ROWS + 1; c <= ROWS + W + 5 && dc == 0; c++) begin
         @(negedge clk);
         if (done === 1'b1) dc = c;
         @(posedge clk); #1;
      end
      chk({tag, "_done_cycle"}, 32'(dc), 32'(ROWS + W + 1));
      @(negedge clk);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy !== 1'b0 && t < 60) begin
         @(posedge clk); #1;
         t++;
      end
      chk({tag, "_idle_in_time"}, 32'(t < 60), 32'd1);
   endtask

   initial begin
      int nv, nd;
      vecs[0] = '{x:4'b1001, z:4'b0110, l:4'b1100, rows:12'b10_01_01_10_11_00, mod_x:1'b0};
      vecs[1] = '{x:4'b1001, z:4'b0110, l:4'b1100, rows:12'b10_01_01_10_11_00, mod_x:1'b1};
      vecs[2] = '{x:4'b0011, z:4'b1110, l:4'b0101, rows:12'b00_11_11_10_01_01, mod_x:1'b0};
      vecs[3] = '{x:4'b1111, z:4'b0000, l:4'b1010, rows:12'b11_11_00_00_10_10, mod_x:1'b1};

      rst_new = 1'b0; start = 1'b0; x_block = '0; z_block = '0; lit_block = '0;
      #2 rst_new = 1'b1;
      #1;
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_row",   32'(row_out),   32'd0);
      chk("rst_blk",   32'(row_blk),   32'd0);
      chk("rst_idx",   row_idx,        32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      #14 rst_new = 1'b0;
      @(posedge clk); #1;
      chk_en = 1;

      nv = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid_out === 1'b1) nv++;
      end
      chk("idle_after_reset_valid", 32'(nv), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

      // Extra start pulses during SEND (cycle 3) and WAIT (cycle 10) must be dropped.
      x_block = vecs[0].x; z_block = vecs[0].z; lit_block = vecs[0].l; start = 1'b1;
      @(posedge clk); #1;
      nv = 0; nd = 0;
      for (int c = 1; c <= 30; c++) begin
         start = (c == 3 || c == 10);
         if (c == 3) x_block = 4'b0110;
         @(negedge clk);
         if (valid_out === 1'b1) nv++;
         if (done === 1'b1) nd++;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("ignored_start_valid_count", 32'(nv), 32'(ROWS));
      chk("ignored_start_done_count",  32'(nd), 32'd1);

      // Start held high: second burst begins WAIT+2 idle cycles after the first.
      x_block = vecs[2].x; z_block = vecs[2].z; lit_block = vecs[2].l; start = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk); #1;
         if (c == 20) start = 1'b0;
         @(negedge clk);
         chk($sformatf("b2b_valid_c%0d", c), 32'(valid_out),
             32'((c <= ROWS) || (c >= ROWS + W + 3 && c <= 2*ROWS + W + 2)));
      end
      @(posedge clk); #1;
      wait_idle("b2b");

      // Abort mid-SEND with an asynchronous reset.
      x_block = vecs[0].x; z_block = vecs[0].z; lit_block = vecs[0].l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      #2 rst_new = 1'b1;
      #1;
      chk("abort_valid", 32'(valid_out), 32'd0);
      chk("abort_busy",  32'(busy),      32'd0);
      #1 rst_new = 1'b0;
      @(posedge clk); #1;
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
         @(posedge clk); #1;
      end
      chk("abort_no_done", 32'(nd), 32'd0);
      run_burst(vecs[2], "after_abort");

      // Random starts and block changes; the scoreboard checks every cycle.
      for (int c = 0; c < 400; c++) begin
         start = ($urandom_range(3) == 0);
         if ($urandom_range(1) == 1) begin
            x_block   = NN'($urandom);
            z_block   = NN'($urandom);
            lit_block = NN'($urandom);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      wait_idle("random");
      @(negedge clk);
      chk_en = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
